// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Purpose
//   Parametrised pipeline stage register with a 2-entry skid buffer. It carries
//   one DW-bit payload between two core stages (IF/ID, ID/EX, EX/MEM) using
//   valid/ready handshakes on both sides. in_ready_o comes straight from a flop,
//   so there is no combinational path from out_ready_i to in_ready_o. While the
//   stage is empty, or after a flush, out_data_o shows NOP_DATA (a bubble).
//
// Handshake semantics (both sides)
//   A transfer happens on a rising clk edge when valid and ready are both 1.
//   A producer holding valid=1 keeps its data stable until the transfer. The
//   downstream payload (out_valid_o/out_data_o) stays constant while it is
//   stalled. in_ready_o and out_valid_o are registered.
//
// Parameters
//   DW        payload width in bits (>= 1)
//   NOP_DATA  payload driven while the stage is empty or after a flush
//   CNT_W     perf counter width (only used when PIPE_STAGE_PERF_EN is defined)
//
// Configuration macro
//   PIPE_STAGE_PERF_EN  when defined, adds the saturating stall_cnt_o and
//                       flush_cnt_o counters. When undefined, neither the ports
//                       nor the counter flops exist.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-low
//   flush_i      in   1      synchronous flush: drop all held entries
//   in_valid_i   in   1      upstream payload valid
//   in_ready_o   out  1      stage can accept (registered)
//   in_data_i    in   DW     upstream payload
//   out_valid_o  out  1      payload valid to downstream
//   out_ready_i  in   1      downstream accepts (0 = stall)
//   out_data_o   out  DW     payload to downstream (main register)
//   occupancy_o  out  2      entries held: 0, 1 or 2 (also the FSM state)
//   stall_cnt_o  out  CNT_W  [PERF] cycles with out_valid_o=1 and out_ready_i=0
//   flush_cnt_o  out  CNT_W  [PERF] cycles with flush_i=1
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int              DW       = 32,
   parameter logic [DW-1:0]   NOP_DATA = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [DW-1:0]    in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [DW-1:0]    out_data_o,
   output logic [1:0]       occupancy_o
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
`endif
);

   // Reject bad parameter values at elaboration time.
   if (DW < 1 || CNT_W < 1) begin : g_bad_param
      $error("pipe_stage_skid: DW and CNT_W must both be >= 1");
   end

   // The encoding equals the number of held entries, so occupancy_o is
   // simply the state register.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state_q;
   logic [DW-1:0]   main_q;     // head entry, drives out_data_o
   logic [DW-1:0]   skid_q;     // second entry, valid only in FULL
   logic            ready_q;    // registered in_ready_o
   logic            valid_q;    // registered out_valid_o

   logic            in_xfer;
   logic            out_xfer;

   assign in_xfer  = in_valid_i & ready_q;
   assign out_xfer = valid_q & out_ready_i;

   assign in_ready_o  = ready_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = main_q;
   assign occupancy_o = state_q;

   // ---------------------------------------------------------------------------
   // Stage FSM. Every output is a flop that is updated together with the state,
   // so in_ready_o is "next state != FULL" and out_valid_o is
   // "next state != EMPTY", both captured at the edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= NOP_DATA;
         skid_q  <= NOP_DATA;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         // A flush overrides everything. An entry accepted in the same cycle is
         // dropped, and an entry taken by downstream in the same cycle has
         // already left the stage.
         state_q <= EMPTY;
         main_q  <= NOP_DATA;
         skid_q  <= NOP_DATA;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  main_q  <= in_data_i;
                  state_q <= ONE;
                  valid_q <= 1'b1;
               end
            end

            ONE: begin
               case ({in_xfer, out_xfer})
                  2'b11: begin
                     // Pass-through: the head leaves and the new entry replaces it.
                     main_q <= in_data_i;
                  end
                  2'b10: begin
                     // Downstream stalled: park the newcomer in the skid slot.
                     skid_q  <= in_data_i;
                     state_q <= FULL;
                     ready_q <= 1'b0;
                  end
                  2'b01: begin
                     main_q  <= NOP_DATA;
                     state_q <= EMPTY;
                     valid_q <= 1'b0;
                  end
                  default: begin
                     // Nothing moves; hold.
                  end
               endcase
            end

            FULL: begin
               // ready_q is 0 here, so in_xfer cannot occur.
               if (out_xfer) begin
                  main_q  <= skid_q;
                  skid_q  <= NOP_DATA;
                  state_q <= ONE;
                  ready_q <= 1'b1;
               end
            end

            default: begin
               // The unused encoding returns to a clean empty stage.
               state_q <= EMPTY;
               main_q  <= NOP_DATA;
               skid_q  <= NOP_DATA;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Structural invariants: the registered handshake flags always agree with
   // the state.
   // ---------------------------------------------------------------------------
   a_ready_matches_state : assert property (@(posedge clk) disable iff (!rst)
      ready_q == (state_q != FULL));

   a_valid_matches_state : assert property (@(posedge clk) disable iff (!rst)
      valid_q == (state_q != EMPTY));

`ifdef PIPE_STAGE_PERF_EN
   // ---------------------------------------------------------------------------
   // Saturating performance counters. They are cleared only by reset; a flush
   // does not clear them.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (valid_q && !out_ready_i && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (flush_i && !(&flush_cnt_q)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

   localparam int          DW    = 32;
   localparam int          CNT_W = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic          clk;
   logic          rst;
   logic          flush_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] out_data_o;
   logic [1:0]    occupancy_o;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   pipe_stage_skid #(
      .DW       (DW),
      .NOP_DATA (NOP),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .occupancy_o (occupancy_o)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string tag, input logic ev, input logic [31:0] ed,
                           input logic [1:0] eo, input logic er);
      chk({tag, ".out_valid"}, {31'd0, out_valid_o}, {31'd0, ev});
      chk({tag, ".out_data"},  out_data_o, ed);
      chk({tag, ".occupancy"}, {30'd0, occupancy_o}, {30'd0, eo});
      chk({tag, ".in_ready"},  {31'd0, in_ready_o}, {31'd0, er});
   endtask

   // ---------------- driver ----------------
   // Drive inputs at the falling edge, let one rising edge happen, then sample
   // 1 time unit later.
   task automatic step(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
      @(negedge clk);
      flush_i     = f;
      in_valid_i  = iv;
      in_data_i   = d;
      out_ready_i = ordy;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        flush;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        ev;
      logic [31:0] ed;
      logic [1:0]  eo;
      logic        er;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic f, input logic iv, input logic [31:0] d, input logic ordy,
                      input logic ev, input logic [31:0] ed, input logic [1:0] eo, input logic er);
      vec_t v;
      v.flush = f;  v.iv = iv; v.d = d;   v.ordy = ordy;
      v.ev    = ev; v.ed = ed; v.eo = eo; v.er   = er;
      vt.push_back(v);
   endtask

   // ---------------- scoreboard model for random test ----------------
   logic [31:0] exp_q[$];

   initial begin
      rst         = 1'b1;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b0;

      // ---- 1: reset, checked before any clock edge (asynchronous) ----
      #2 rst = 1'b0;
      #1;
      chk_outs("reset", 1'b0, NOP, 2'd0, 1'b1);
      // Inputs are ignored while reset is held.
      in_valid_i  = 1'b1;
      in_data_i   = 32'hDEAD_BEEF;
      out_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset_hold", 1'b0, NOP, 2'd0, 1'b1);
      @(negedge clk);
      in_valid_i = 1'b0;
      rst        = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         chk_outs($sformatf("idle%0d", i), 1'b0, NOP, 2'd0, 1'b1);
      end

      // ---- directed table: stream, skid, hold, flush ----
      //   flush iv  data          ordy  ev   exp_data      occ   rdy
      add(1'b0, 1'b1, 32'h11, 1'b1,  1'b1, 32'h11, 2'd1, 1'b1);
      add(1'b0, 1'b1, 32'h22, 1'b1,  1'b1, 32'h22, 2'd1, 1'b1);
      add(1'b0, 1'b1, 32'h33, 1'b1,  1'b1, 32'h33, 2'd1, 1'b1);
      add(1'b0, 1'b0, 32'h00, 1'b1,  1'b0, NOP,    2'd0, 1'b1);
      add(1'b0, 1'b1, 32'hA1, 1'b0,  1'b1, 32'hA1, 2'd1, 1'b1);
      add(1'b0, 1'b1, 32'hA2, 1'b0,  1'b1, 32'hA1, 2'd2, 1'b0);
      add(1'b0, 1'b0, 32'h00, 1'b0,  1'b1, 32'hA1, 2'd2, 1'b0);
      add(1'b0, 1'b1, 32'h55, 1'b0,  1'b1, 32'hA1, 2'd2, 1'b0);  // refused: full
      add(1'b0, 1'b0, 32'h00, 1'b1,  1'b1, 32'hA2, 2'd1, 1'b1);
      add(1'b0, 1'b0, 32'h00, 1'b1,  1'b0, NOP,    2'd0, 1'b1);
      add(1'b0, 1'b1, 32'hD1, 1'b0,  1'b1, 32'hD1, 2'd1, 1'b1);
      add(1'b0, 1'b0, 32'h00, 1'b0,  1'b1, 32'hD1, 2'd1, 1'b1);  // hold in ONE
      add(1'b0, 1'b0, 32'h00, 1'b1,  1'b0, NOP,    2'd0, 1'b1);
      add(1'b0, 1'b1, 32'hB1, 1'b0,  1'b1, 32'hB1, 2'd1, 1'b1);
      add(1'b0, 1'b1, 32'hB2, 1'b0,  1'b1, 32'hB1, 2'd2, 1'b0);
      add(1'b1, 1'b1, 32'hB3, 1'b0,  1'b0, NOP,    2'd0, 1'b1);  // flush while full
      add(1'b0, 1'b0, 32'h00, 1'b1,  1'b0, NOP,    2'd0, 1'b1);
      add(1'b0, 1'b1, 32'hC1, 1'b0,  1'b1, 32'hC1, 2'd1, 1'b1);
      add(1'b1, 1'b1, 32'hC2, 1'b1,  1'b0, NOP,    2'd0, 1'b1);  // flush + in + out
      add(1'b0, 1'b0, 32'h00, 1'b1,  1'b0, NOP,    2'd0, 1'b1);
      add(1'b0, 1'b1, 32'hE1, 1'b0,  1'b1, 32'hE1, 2'd1, 1'b1);
      add(1'b0, 1'b1, 32'hE2, 1'b0,  1'b1, 32'hE1, 2'd2, 1'b0);
      add(1'b0, 1'b1, 32'hE3, 1'b1,  1'b1, 32'hE2, 2'd1, 1'b1);  // E3 refused
      add(1'b0, 1'b1, 32'hE4, 1'b1,  1'b1, 32'hE4, 2'd1, 1'b1);
      add(1'b0, 1'b0, 32'h00, 1'b1,  1'b0, NOP,    2'd0, 1'b1);

      foreach (vt[i]) begin
         step(vt[i].flush, vt[i].iv, vt[i].d, vt[i].ordy);
         chk_outs($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].eo, vt[i].er);
      end

      // ---- reset asserted mid-operation ----
      step(1'b0, 1'b1, 32'hF1, 1'b0);
      step(1'b0, 1'b1, 32'hF2, 1'b0);
      chk_outs("pre_rst", 1'b1, 32'hF1, 2'd2, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk_outs("mid_rst", 1'b0, NOP, 2'd0, 1'b1);
      @(negedge clk);
      rst        = 1'b1;
      in_valid_i = 1'b0;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk_outs("post_rst", 1'b0, NOP, 2'd0, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
      // ---- perf counters (CNT_W = 4) ----
      chk("stall_cnt_rst", {28'd0, stall_cnt_o}, 32'd0);
      chk("flush_cnt_rst", {28'd0, flush_cnt_o}, 32'd0);
      step(1'b0, 1'b1, 32'h77, 1'b0);
      chk("stall_cnt_0", {28'd0, stall_cnt_o}, 32'd0);
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         if (i == 5)  chk("stall_cnt_5",  {28'd0, stall_cnt_o}, 32'd5);
         if (i == 20) chk("stall_cnt_20", {28'd0, stall_cnt_o}, 32'd15);
      end
      chk("flush_cnt_0", {28'd0, flush_cnt_o}, 32'd0);
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("flush_cnt_3", {28'd0, flush_cnt_o}, 32'd3);
      chk("stall_cnt_sat", {28'd0, stall_cnt_o}, 32'd15);
      chk_outs("perf_end", 1'b0, NOP, 2'd0, 1'b1);
`endif

      // ---- random traffic against a queue model ----
      exp_q.delete();
      for (int n = 0; n < 4000; n++) begin
         logic f, iv, ordy, m_in, m_out;
         logic [31:0] d;
         @(negedge clk);
         chk("rnd.occupancy", {30'd0, occupancy_o}, exp_q.size());
         chk("rnd.in_ready",  {31'd0, in_ready_o},  {31'd0, exp_q.size() != 2});
         chk("rnd.out_valid", {31'd0, out_valid_o}, {31'd0, exp_q.size() != 0});
         chk("rnd.out_data",  out_data_o, (exp_q.size() != 0) ? exp_q[0] : NOP);
         f    = ($urandom_range(0, 99) < 5);
         iv   = $urandom_range(0, 1) == 1;
         ordy = $urandom_range(0, 2) != 0;
         d    = $urandom;
         flush_i     = f;
         in_valid_i  = iv;
         in_data_i   = d;
         out_ready_i = ordy;
         m_in  = iv && (exp_q.size() != 2);
         m_out = ordy && (exp_q.size() != 0);
         if (m_out) void'(exp_q.pop_front());
         if (m_in)  exp_q.push_back(d);
         if (f)     exp_q.delete();
      end
      @(negedge clk);
      chk("rnd.final_occ", {30'd0, occupancy_o}, exp_q.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
